// File: rtl/layer4_pixel_buffer_pkg.sv
// Shared constants and state encoding for the layer-4 pixel buffer.
// Frame geometry follows the layer-3 pooled output; pixel width follows the
// layer-3 channel packing; addresses use the system word length.
package layer4_pixel_buffer_pkg;

  localparam int LAYER4_WIDTH         = 16;
  localparam int LAYER3_OUTPUT_LENGTH = 128;
  localparam int WORDLENGTH           = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    FULL = 2'b10
  } state_t;

endpackage

// File: rtl/layer4_pixel_buffer_pixel_ram_1r1w.sv
// Simple dual-port frame RAM: one synchronous write port, one registered read port.
// Latency: read data appears one cycle after rd_en; holds while rd_en is low.
// Same-address read and write in one cycle returns the old contents.
module pixel_ram_1r1w #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read share one edge; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/layer4_pixel_buffer.sv
// Frame store between layer-3 pooling and layer-4: captures a WIDTH x WIDTH frame, flags completion.
// Latency: writes land on the same edge; reads return one cycle after read_pixel_signal.
// No backpressure: writes in FULL are dropped and flagged; out-of-range reads return zero.
module layer4_pixel_buffer
  import layer4_pixel_buffer_pkg::*;
#(
  parameter int WIDTH  = LAYER4_WIDTH,
  parameter int DATA_W = LAYER3_OUTPUT_LENGTH,
  parameter int ADDR_W = WORDLENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [ADDR_W-1:0] input_row,
  input  logic [ADDR_W-1:0] input_col,
  input  logic [DATA_W-1:0] input_data,
  input  logic              layer3_calculation_done,
  input  logic              read_pixel_signal,
  input  logic [ADDR_W-1:0] read_row_addr,
  input  logic [ADDR_W-1:0] read_col_addr,
  input  logic              buffer_release,
  output logic [DATA_W-1:0] output_data,
  output logic              pixel_store_done,
  output logic              buffer_full,
  output logic              store_error
);

  localparam int DEPTH = WIDTH * WIDTH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   write_count;
  logic               wr_in_range;
  logic               rd_in_range;
  logic               accept;
  logic               completes;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_pad_q;
  logic [DATA_W-1:0]  ram_q;

  assign wr_in_range = (32'(input_row) < 32'(WIDTH)) && (32'(input_col) < 32'(WIDTH));
  assign rd_in_range = (32'(read_row_addr) < 32'(WIDTH)) && (32'(read_col_addr) < 32'(WIDTH));

  // Constant WIDTH multiplier; reduces to a shift for power-of-two frames.
  assign wr_idx = IDX_W'(32'(input_row) * 32'(WIDTH) + 32'(input_col));
  assign rd_idx = IDX_W'(32'(read_row_addr) * 32'(WIDTH) + 32'(read_col_addr));

  assign accept    = save_enable && wr_in_range && (state != FULL);
  assign completes = accept && (write_count == CNT_W'(DEPTH - 1));

  pixel_ram_1r1w #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_idx),
    .wr_data (input_data),
    .rd_en   (read_pixel_signal && rd_in_range),
    .rd_addr (rd_idx),
    .rd_data (ram_q)
  );

  // Remember whether the last read was a padding read; the RAM register is left untouched then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_pad_q <= 1'b1;
    else if (read_pixel_signal) rd_pad_q <= !rd_in_range;
  end

  assign output_data = rd_pad_q ? '0 : ram_q;

  // Frame-fill FSM: count accepted writes, flag completion, police producer misbehaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      write_count      <= '0;
      pixel_store_done <= 1'b0;
      buffer_full      <= 1'b0;
      store_error      <= 1'b0;
    end else begin
      pixel_store_done <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            write_count <= write_count + 1'b1;
            if (completes) begin
              state            <= FULL;
              pixel_store_done <= 1'b1;
              buffer_full      <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
          if (layer3_calculation_done && !completes) store_error <= 1'b1;
        end
        FULL: begin
          if (save_enable) store_error <= 1'b1;
          if (buffer_release) begin
            state       <= IDLE;
            write_count <= '0;
            buffer_full <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer4_pixel_buffer.sv
// Randomized and directed bench for layer4_pixel_buffer against a frame-level reference model.
module tb_layer4_pixel_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         save_enable = 1'b0;
  logic [15:0]  input_row = '0;
  logic [15:0]  input_col = '0;
  logic [127:0] input_data = '0;
  logic         layer3_calculation_done = 1'b0;
  logic         read_pixel_signal = 1'b0;
  logic [15:0]  read_row_addr = '0;
  logic [15:0]  read_col_addr = '0;
  logic         buffer_release = 1'b0;
  logic [127:0] output_data;
  logic         pixel_store_done;
  logic         buffer_full;
  logic         store_error;

  always #5 clk = ~clk;

  layer4_pixel_buffer dut (
    .clk                     (clk),
    .rst                     (rst),
    .save_enable             (save_enable),
    .input_row               (input_row),
    .input_col               (input_col),
    .input_data              (input_data),
    .layer3_calculation_done (layer3_calculation_done),
    .read_pixel_signal       (read_pixel_signal),
    .read_row_addr           (read_row_addr),
    .read_col_addr           (read_col_addr),
    .buffer_release          (buffer_release),
    .output_data             (output_data),
    .pixel_store_done        (pixel_store_done),
    .buffer_full             (buffer_full),
    .store_error             (store_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame contents, pixels written this frame, frame-held flag, sticky error.
  logic [127:0] mem_m [256];
  int           writes_m;
  bit           held_m;
  bit           err_m;
  logic [127:0] out_m;
  bit           done_e;
  int           done_seen;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pix(input logic [15:0] v);
    return {8{v}};
  endfunction

  function automatic logic [15:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 16'hFFFF;
    if (k == 1) return 16'(16 + $urandom_range(0, 3));
    return 16'($urandom_range(0, 15));
  endfunction

  function automatic logic [127:0] rand_pix();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wr(input logic [15:0] r, input logic [15:0] c, input logic [127:0] d);
    save_enable = 1'b1;
    input_row   = r;
    input_col   = c;
    input_data  = d;
  endtask

  task automatic rd(input logic [15:0] r, input logic [15:0] c);
    read_pixel_signal = 1'b1;
    read_row_addr     = r;
    read_col_addr     = c;
  endtask

  // Apply the currently driven inputs for one cycle and compare every output with the model.
  task automatic step(input string tag);
    bit in_w;
    bit in_r;
    done_e = 1'b0;
    in_w = (input_row < 16) && (input_col < 16);
    in_r = (read_row_addr < 16) && (read_col_addr < 16);
    if (read_pixel_signal)
      out_m = in_r ? mem_m[int'(read_row_addr) * 16 + int'(read_col_addr)] : '0;
    if (held_m) begin
      if (save_enable) err_m = 1'b1;
      if (buffer_release) begin
        held_m   = 1'b0;
        writes_m = 0;
      end
    end else begin
      if (save_enable && in_w) begin
        mem_m[int'(input_row) * 16 + int'(input_col)] = input_data;
        writes_m++;
        if (writes_m == 256) begin
          held_m = 1'b1;
          done_e = 1'b1;
        end
      end
      if (layer3_calculation_done && !done_e) err_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (pixel_store_done) done_seen++;
    check({tag, ".done"}, 128'(pixel_store_done), 128'(done_e));
    check({tag, ".full"}, 128'(buffer_full), 128'(held_m));
    check({tag, ".err"},  128'(store_error), 128'(err_m));
    check({tag, ".data"}, output_data, out_m);
    save_enable             = 1'b0;
    read_pixel_signal       = 1'b0;
    layer3_calculation_done = 1'b0;
    buffer_release          = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    writes_m = 0;
    held_m   = 1'b0;
    err_m    = 1'b0;
    out_m    = '0;
    check("rst.done", 128'(pixel_store_done), 128'(0));
    check("rst.full", 128'(buffer_full), 128'(0));
    check("rst.err",  128'(store_error), 128'(0));
    check("rst.data", output_data, 128'(0));
  endtask

  logic [127:0] old_val;

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    done_seen = 0;
    do_reset();

    // 1: raster fill with data derived from the address
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        wr(16'(r), 16'(c), pix(16'(r * 16 + c)));
        step("t1_fill");
      end
    check("t1_done_count", 128'(done_seen), 128'(1));
    check("t1_full", 128'(buffer_full), 128'(1));
    check("t1_err",  128'(store_error), 128'(0));

    // 2: in-range read and padding reads
    rd(16'd3, 16'd5);
    step("t2_rd35");
    check("t2_val35", output_data, pix(16'd53));
    rd(16'hFFFF, 16'd0);
    step("t2_rdneg");
    check("t2_pad_neg", output_data, 128'(0));
    rd(16'd0, 16'd16);
    step("t2_rdcol16");
    check("t2_pad_col", output_data, 128'(0));

    // 3: overrun while FULL
    wr(16'd0, 16'd0, '1);
    step("t3_overrun");
    check("t3_err", 128'(store_error), 128'(1));
    rd(16'd0, 16'd0);
    step("t3_rd00");
    check("t3_val00", output_data, pix(16'd0));

    // 4: early end-of-frame pulse
    do_reset();
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      wr(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), rand_pix());
      step("t4_fill");
    end
    layer3_calculation_done = 1'b1;
    step("t4_l3done");
    check("t4_err", 128'(store_error), 128'(1));
    check("t4_state", 128'(dut.state), 128'(2'b01));
    check("t4_done_count", 128'(done_seen), 128'(0));

    // 5: reset mid-fill, then a full frame
    for (int i = 0; i < 120; i++) begin
      wr(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), rand_pix());
      step("t5_pre");
    end
    do_reset();
    done_seen = 0;
    for (int i = 0; i < 256; i++) begin
      wr(16'(i / 16), 16'(i % 16), rand_pix());
      step("t5_fill");
      if (i == 254) check("t5_no_early_done", 128'(done_seen), 128'(0));
    end
    check("t5_done_count", 128'(done_seen), 128'(1));

    // 6: release, then same-cycle read and write of one pixel
    old_val = mem_m[2 * 16 + 2];
    buffer_release = 1'b1;
    step("t6_release");
    wr(16'd2, 16'd2, pix(16'hABCD));
    rd(16'd2, 16'd2);
    step("t6_rw");
    check("t6_old", output_data, old_val);
    rd(16'd2, 16'd2);
    step("t6_rd");
    check("t6_new", output_data, pix(16'hABCD));
    check("t6_state", 128'(dut.state), 128'(2'b01));
    check("t6_count", 128'(dut.write_count), 128'(1));

    // Random soak: mixed writes, reads, releases, stray done pulses and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 1) == 1) wr(rand_addr(), rand_addr(), rand_pix());
        if ($urandom_range(0, 1) == 1) rd(rand_addr(), rand_addr());
        if ($urandom_range(0, 29) == 0) buffer_release = 1'b1;
        if ($urandom_range(0, 199) == 0) layer3_calculation_done = 1'b1;
        step("soak");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
